// File: rtl/rx_datapath_pkg.sv
// rx_datapath_pkg: shared UART receive constants, frame field type and length helper
package rx_datapath_pkg;
  localparam int SR_W = 10;
  localparam logic [3:0] LEN_7N = 4'd8;
  localparam logic [3:0] LEN_7P = 4'd9;
  localparam logic [3:0] LEN_8N = 4'd9;
  localparam logic [3:0] LEN_8P = 4'd10;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       stop;
  } frame_t;
  function automatic logic [3:0] frame_len(input logic eight, input logic pen);
    return eight ? (pen ? LEN_8P : LEN_8N) : (pen ? LEN_7P : LEN_7N);
  endfunction
endpackage

// File: rtl/rx_datapath.sv
// rx_datapath: RX shift register, frame alignment, parity/stop checks and status flags
module rx_datapath #(
  parameter int SR_W = rx_datapath_pkg::SR_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       BTU,
  input  logic       START,
  input  logic       DONE,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic       READ,
  output logic [7:0] UART_RDATA,
  output logic       RXRDY,
  output logic       PERR,
  output logic       FERR,
  output logic       OVF
);
  import rx_datapath_pkg::*;
  logic [SR_W-1:0] sr_q, aligned;
  logic [3:0] n;
  logic done_q, done_edge;
  frame_t fr;
  logic [7:0] rdata_q, rdata_d;
  logic rxrdy_q, rxrdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr_q <= '0;
    else if (BTU && !START) sr_q <= {RX, sr_q[SR_W-1:1]};
  always_ff @(posedge clk or posedge rst)
    if (rst) done_q <= 1'b0;
    else done_q <= DONE;
  // Freshest n bits sit at the top of the shift register; drop the stale tail.
  always_comb begin
    n          = frame_len(EIGHT, PEN);
    aligned    = sr_q >> (SR_W - int'(n));
    fr.data    = {EIGHT & aligned[7], aligned[6:0]};
    fr.par     = aligned[n - 4'd2];
    fr.stop    = aligned[n - 4'd1];
    done_edge  = DONE & ~done_q;
    rdata_d    = done_edge ? fr.data : rdata_q;
    rxrdy_d    = done_edge | (rxrdy_q & ~READ);
    perr_d     = done_edge ? PEN & (fr.par != (^fr.data ^ OHEL)) : perr_q & ~READ;
    ferr_d     = done_edge ? ~fr.stop : ferr_q & ~READ;
    ovf_d      = ~READ & (ovf_q | (done_edge & rxrdy_q));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdata_q <= '0;
      rxrdy_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rxrdy_q <= rxrdy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  assign UART_RDATA = rdata_q;
  assign RXRDY      = rxrdy_q;
  assign PERR       = perr_q;
  assign FERR       = ferr_q;
  assign OVF        = ovf_q;
endmodule

// File: tb/tb_rx_datapath.sv
// tb_rx_datapath: directed and random frames against a frame-level reference model
module tb_rx_datapath;
  logic clk = 1'b0;
  logic rst, RX, BTU, START, DONE, EIGHT, PEN, OHEL, READ;
  logic [7:0] UART_RDATA;
  logic RXRDY, PERR, FERR, OVF;
  int vectors = 0, miscompares = 0;
  logic [7:0] m_data;
  logic m_rdy, m_perr, m_ferr, m_ovf;
  logic [7:0] p_d;
  logic p_eight, p_pen, p_ohel, p_par, p_stop;

  rx_datapath dut (
    .clk(clk), .rst(rst), .RX(RX), .BTU(BTU), .START(START), .DONE(DONE),
    .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL), .READ(READ),
    .UART_RDATA(UART_RDATA), .RXRDY(RXRDY), .PERR(PERR), .FERR(FERR), .OVF(OVF)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rdata"}, UART_RDATA, m_data);
    check({tag, ".rxrdy"}, {7'd0, RXRDY}, {7'd0, m_rdy});
    check({tag, ".perr"}, {7'd0, PERR}, {7'd0, m_perr});
    check({tag, ".ferr"}, {7'd0, FERR}, {7'd0, m_ferr});
    check({tag, ".ovf"}, {7'd0, OVF}, {7'd0, m_ovf});
  endtask

  // Wire order: data LSB first (7 or 8 bits), optional parity, stop.
  task automatic shift_frame(input logic [7:0] d, input logic eight, input logic pen,
                             input logic ohel, input logic par, input logic stop, input int nsend);
    logic bits[$];
    bits = {};
    for (int i = 0; i < (eight ? 8 : 7); i++) bits.push_back(d[i]);
    if (pen) bits.push_back(par);
    bits.push_back(stop);
    p_d = d; p_eight = eight; p_pen = pen; p_ohel = ohel; p_par = par; p_stop = stop;
    EIGHT = eight; PEN = pen; OHEL = ohel;
    START = 1'b1; BTU = 1'b1; RX = 1'b1;
    tick;
    BTU = 1'b0;
    tick;
    START = 1'b0;
    for (int i = 0; i < bits.size() && (nsend < 0 || i < nsend); i++) begin
      RX = bits[i]; BTU = 1'b1;
      tick;
      BTU = 1'b0; RX = $urandom_range(0, 1);
      tick;
    end
  endtask

  task automatic model_frame(input logic rd);
    int ones;
    logic pexp;
    m_ovf  = rd ? 1'b0 : (m_ovf | m_rdy);
    m_rdy  = 1'b1;
    m_data = p_eight ? p_d : {1'b0, p_d[6:0]};
    ones   = $countones(m_data) + int'(p_ohel);
    pexp   = (ones % 2) == 1;
    m_perr = p_pen && (p_par != pexp);
    m_ferr = !p_stop;
  endtask

  task automatic done_edge(input logic rd, input string tag);
    DONE = 1'b1; READ = rd;
    tick;
    model_frame(rd);
    check_all(tag);
    READ = 1'b0;
    tick;
    DONE = 1'b0;
    tick;
  endtask

  task automatic host_read(input string tag);
    READ = 1'b1;
    tick;
    READ = 1'b0;
    m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    check_all(tag);
  endtask

  task automatic frame(input logic [7:0] d, input logic eight, input logic pen, input logic ohel,
                       input logic par, input logic stop, input logic rd, input string tag);
    shift_frame(d, eight, pen, ohel, par, stop, -1);
    done_edge(rd, tag);
  endtask

  initial begin
    rst = 1'b1; RX = 1'b1; BTU = 1'b0; START = 1'b0; DONE = 1'b0;
    EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0; READ = 1'b0;
    m_data = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    tick; tick;
    check_all("reset");
    rst = 1'b0;
    tick;

    // 8N 0xA5, DONE held 3 clocks with a READ inside: the level must not re-trigger.
    shift_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    DONE = 1'b1;
    tick;
    model_frame(1'b0);
    check_all("8n_a5");
    READ = 1'b1;
    tick;
    READ = 1'b0;
    m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    tick;
    check_all("done_held");
    DONE = 1'b0;
    tick;

    frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "7p_even_ok");
    host_read("read1");
    frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "7p_even_bad");
    host_read("read2");
    frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "8p_odd_ok");
    host_read("read3");
    frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "8p_stop0");
    host_read("read4");
    frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ovf_first");
    frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ovf_second");
    host_read("ovf_read");
    frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "race_first");
    frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, "race_second");

    // Reset mid-frame: asynchronous clear, then a clean frame.
    shift_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    #2 rst = 1'b1;
    #1;
    m_data = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    check_all("async_rst");
    tick;
    rst = 1'b0;
    tick;
    frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "after_rst");

    for (int k = 0; k < 30; k++) begin
      frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), 1'($urandom), "rand");
      if ($urandom_range(0, 2) == 0) host_read("rand_read");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
